and_gate_test_seq: RTL and testbench

// - Self-test sequencer for the 2-input and_gate datapath: drives input_1/input_2 through all 4 vectors, samples and_result, checks it against input_1 & input_2.
// - Synthesisable on-chip replacement for the hand-timed stimulus bench.
// - Sits between a control master (start/done handshake) and one and_gate instance.
// - Reports pass/fail, error count and per-vector fail mask.

---
 rtl/and_gate_test_seq_pkg.sv | 24 ++
 rtl/and_gate_test_seq_if.sv | 24 ++
 rtl/and_gate_test_seq_settle_timer.sv | 34 +++
 rtl/and_gate_test_seq.sv | 157 +++++++++++++++
 tb/tb_and_gate_test_seq.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/and_gate_test_seq_pkg.sv
// Shared types and constants for the and_gate self-test sequencer.
package and_gate_test_seq_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // A 2-input gate has four truth-table rows; vec_idx is {input_1,input_2}.
    localparam int NUM_VECTORS = 4;
    localparam int VEC_W       = 2;

    // One-hot bit for a vector index, used to build the fail mask.
    function automatic logic [NUM_VECTORS-1:0] vec_onehot(input logic [VEC_W-1:0] v);
        logic [NUM_VECTORS-1:0] m;
        m    = '0;
        m[v] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/and_gate_test_seq_if.sv
// Control-side handshake between a test master and the and_gate sequencer.
interface and_gate_test_seq_if
    import and_gate_test_seq_pkg::*;
#(
    parameter int ERR_CNT_W = 8
);
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [ERR_CNT_W-1:0]   err_count;
    logic [NUM_VECTORS-1:0] fail_mask;
    logic [VEC_W-1:0]       vec_idx;

    modport master (
        output start,
        input  busy, done, pass, err_count, fail_mask, vec_idx
    );

    modport slave (
        input  start,
        output busy, done, pass, err_count, fail_mask, vec_idx
    );
endinterface

// File: rtl/and_gate_test_seq_settle_timer.sv
// Loadable down-counter with a zero flag; times how long each vector settles.
module and_gate_test_seq_settle_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Load has priority; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/and_gate_test_seq.sv
// Self-test sequencer for a 2-input and_gate: walks the truth table RUNS times,
// holds each vector SETTLE_CYCLES cycles, samples and_result and tallies mismatches.
module and_gate_test_seq
    import and_gate_test_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int RUNS          = 1,
    parameter int ERR_CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    and_gate_test_seq_if.slave ctl,
    output logic               input_1,
    output logic               input_2,
    input  logic               and_result
);
    localparam int TMR_W = $clog2(SETTLE_CYCLES + 1);
    localparam int RUN_W = (RUNS > 1) ? $clog2(RUNS) : 1;

    // The timer is loaded on SETTLE entry and SETTLE exits when it reads zero,
    // so loading N-1 gives exactly N settle cycles.
    localparam logic [TMR_W-1:0]     SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [RUN_W-1:0]     RUN_LAST    = RUN_W'(RUNS - 1);
    localparam logic [VEC_W-1:0]     VEC_LAST    = VEC_W'(NUM_VECTORS - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;

    state_e                 state_q, state_d;
    logic [VEC_W-1:0]       vec_q, vec_d;
    logic [RUN_W-1:0]       run_q, run_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic [NUM_VECTORS-1:0] mask_q, mask_d;
    logic                   pass_q, pass_d;
    logic                   in1_q, in1_d;
    logic                   in2_q, in2_d;
    logic                   tmr_load, tmr_dec, tmr_zero;
    logic                   mismatch;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_MAX) ? v : v + 1'b1;
    endfunction

    and_gate_test_seq_settle_timer #(
        .WIDTH (TMR_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state, vector stepping and result accumulation.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        run_d    = run_q;
        err_d    = err_q;
        mask_d   = mask_q;
        pass_d   = pass_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        mismatch = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctl.start) begin
                    state_d  = ST_SETTLE;
                    vec_d    = '0;
                    run_d    = '0;
                    err_d    = '0;
                    mask_d   = '0;
                    pass_d   = 1'b0;
                    in1_d    = 1'b0;
                    in2_d    = 1'b0;
                    tmr_load = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_SAMPLE: begin
                mismatch = (and_result != (in1_q & in2_q));
                if (mismatch) begin
                    err_d  = sat_inc(err_q);
                    mask_d = mask_q | vec_onehot(vec_q);
                end
                if (vec_q != VEC_LAST) begin
                    vec_d          = vec_q + 1'b1;
                    {in1_d, in2_d} = vec_q + 1'b1;
                    state_d        = ST_SETTLE;
                    tmr_load       = 1'b1;
                end else if (run_q != RUN_LAST) begin
                    run_d          = run_q + 1'b1;
                    vec_d          = '0;
                    {in1_d, in2_d} = 2'b00;
                    state_d        = ST_SETTLE;
                    tmr_load       = 1'b1;
                end else begin
                    // Verdict uses the count including this final sample.
                    state_d = ST_DONE;
                    pass_d  = (err_d == '0);
                    in1_d   = 1'b0;
                    in2_d   = 1'b0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any partial run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            run_q   <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            run_q   <= run_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
        end
    end

    assign input_1       = in1_q;
    assign input_2       = in2_q;
    assign ctl.busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign ctl.done      = (state_q == ST_DONE);
    assign ctl.pass      = pass_q;
    assign ctl.err_count = err_q;
    assign ctl.fail_mask = mask_q;
    assign ctl.vec_idx   = vec_q;
endmodule

// File: tb/tb_and_gate_test_seq.sv
// Bench for and_gate_test_seq: three sequencer configurations, each with its own
// gate model (good / stuck-at-1 / stuck-at-0 / OR), checked by a scoreboard.
module tb_and_gate_test_seq;
    localparam int NI = 3;

    typedef struct packed {
        int vec;
        bit first;
    } vexp_t;

    typedef struct packed {
        int done_cyc;
        int err;
        int mask;
        bit pass;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    wire [NI-1:0] i1;
    wire [NI-1:0] i2;
    wire [NI-1:0] ar;
    int           mode [NI];
    int           free_at [NI];
    vexp_t        vq [NI][$];
    rexp_t        rq [NI][$];

    and_gate_test_seq_if #(.ERR_CNT_W(8)) if0 ();
    and_gate_test_seq_if #(.ERR_CNT_W(8)) if1 ();
    and_gate_test_seq_if #(.ERR_CNT_W(2)) if2 ();

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Configuration table: SETTLE_CYCLES, RUNS, ERR_CNT_W per instance.
    function automatic int s_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction
    function automatic int r_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
    endfunction
    function automatic int w_of(input int i);
        return (i == 2) ? 2 : 8;
    endfunction

    // Gate under test: 0 good AND, 1 stuck-at-1, 2 stuck-at-0, 3 OR.
    function automatic logic gate(input int m, input logic a, input logic b);
        case (m)
            0:       return a & b;
            1:       return 1'b1;
            2:       return 1'b0;
            default: return a | b;
        endcase
    endfunction

    assign ar[0] = gate(mode[0], i1[0], i2[0]);
    assign ar[1] = gate(mode[1], i1[1], i2[1]);
    assign ar[2] = gate(mode[2], i1[2], i2[2]);

    and_gate_test_seq #(.SETTLE_CYCLES(2), .RUNS(1), .ERR_CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .ctl(if0.slave),
        .input_1(i1[0]), .input_2(i2[0]), .and_result(ar[0])
    );
    and_gate_test_seq #(.SETTLE_CYCLES(2), .RUNS(3), .ERR_CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .ctl(if1.slave),
        .input_1(i1[1]), .input_2(i2[1]), .and_result(ar[1])
    );
    and_gate_test_seq #(.SETTLE_CYCLES(1), .RUNS(2), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .ctl(if2.slave),
        .input_1(i1[2]), .input_2(i2[2]), .and_result(ar[2])
    );

    task automatic check(input string name, input int i, input bit ok, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, i, act, exp, cyc);
        end
    endtask

    task automatic set_start(input int i, input logic v);
        case (i)
            0:       if0.start = v;
            1:       if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    // Reference model: expected vector stream and end-of-run verdict from the truth table.
    task automatic push_run(input int i, input int x);
        int    s, r, errs, mask, emax, n;
        vexp_t v;
        rexp_t e;
        s    = s_of(i);
        r    = r_of(i);
        n    = 4 * r * (s + 1);
        errs = 0;
        mask = 0;
        for (int run = 0; run < r; run++) begin
            for (int k = 0; k < 4; k++) begin
                int a, b;
                a = k / 2;
                b = k % 2;
                if (int'(gate(mode[i], a[0], b[0])) != (a * b)) begin
                    errs++;
                    mask = mask | (1 << k);
                end
                for (int c = 0; c <= s; c++) begin
                    v.vec   = k;
                    v.first = (run == 0 && k == 0 && c == 0);
                    vq[i].push_back(v);
                end
            end
        end
        emax       = (1 << w_of(i)) - 1;
        e.done_cyc = x + n;
        e.err      = (errs > emax) ? emax : errs;
        e.mask     = mask;
        e.pass     = (errs == 0);
        rq[i].push_back(e);
        free_at[i] = x + n + 2;
    endtask

    // Called at a falling edge; start is seen by the next rising edge.
    task automatic pulse_start(input int i);
        int x;
        x = cyc + 1;
        set_start(i, 1'b1);
        if (x >= free_at[i]) push_run(i, x);
        @(negedge clk);
        set_start(i, 1'b0);
    endtask

    task automatic at_cyc(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic mon(input int i, input logic busy, input logic done, input logic pass,
                       input int err, input int mask, input int vec, input logic a, input logic b);
        vexp_t v;
        rexp_t e;
        if (busy) begin
            check("busy_expected", i, vq[i].size() != 0, 1, 0);
            if (vq[i].size() != 0) begin
                v = vq[i].pop_front();
                check("vector", i, (int'({a, b}) == v.vec) && (vec == v.vec) && !pass && !done,
                      int'({pass, done, a, b}), v.vec);
                if (v.first) check("cleared_at_start", i, (err == 0) && (mask == 0), err * 16 + mask, 0);
            end
        end else if (!done) begin
            check("idle_inputs", i, {a, b} == 2'b00, int'({a, b}), 0);
        end
        if (done) begin
            check("done_expected", i, rq[i].size() != 0, 1, 0);
            if (rq[i].size() != 0) begin
                e = rq[i].pop_front();
                check("done_cycle", i, cyc == e.done_cyc, cyc, e.done_cyc);
                check("err_count", i, err == e.err, err, e.err);
                check("fail_mask", i, mask == e.mask, mask, e.mask);
                check("pass", i, pass == e.pass, int'(pass), int'(e.pass));
                check("vectors_consumed", i, vq[i].size() == 0, vq[i].size(), 0);
                check("done_inputs", i, ({a, b} == 2'b00) && !busy, int'({busy, a, b}), 0);
            end
        end
    endtask

    // Monitors: sample outputs on the falling edge, away from register updates.
    always @(negedge clk) if (!rst) mon(0, if0.busy, if0.done, if0.pass, int'(if0.err_count),
                                        int'(if0.fail_mask), int'(if0.vec_idx), i1[0], i2[0]);
    always @(negedge clk) if (!rst) mon(1, if1.busy, if1.done, if1.pass, int'(if1.err_count),
                                        int'(if1.fail_mask), int'(if1.vec_idx), i1[1], i2[1]);
    always @(negedge clk) if (!rst) mon(2, if2.busy, if2.done, if2.pass, int'(if2.err_count),
                                        int'(if2.fail_mask), int'(if2.vec_idx), i1[2], i2[2]);

    task automatic check_zero();
        check("reset_outputs", 0, {if0.busy, if0.done, if0.pass, if0.err_count, if0.fail_mask,
              if0.vec_idx, i1[0], i2[0]} == '0, int'({if0.busy, if0.done, if0.pass, if0.err_count,
              if0.fail_mask, if0.vec_idx, i1[0], i2[0]}), 0);
        check("reset_outputs", 1, {if1.busy, if1.done, if1.pass, if1.err_count, if1.fail_mask,
              if1.vec_idx, i1[1], i2[1]} == '0, int'({if1.busy, if1.done, if1.pass, if1.err_count,
              if1.fail_mask, if1.vec_idx, i1[1], i2[1]}), 0);
        check("reset_outputs", 2, {if2.busy, if2.done, if2.pass, if2.err_count, if2.fail_mask,
              if2.vec_idx, i1[2], i2[2]} == '0, int'({if2.busy, if2.done, if2.pass, if2.err_count,
              if2.fail_mask, if2.vec_idx, i1[2], i2[2]}), 0);
    endtask

    task automatic flush_all();
        for (int i = 0; i < NI; i++) begin
            vq[i].delete();
            rq[i].delete();
            free_at[i] = 0;
        end
    endtask

    task automatic rand_runs(input int i, input int nruns);
        for (int k = 0; k < nruns; k++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            at_cyc(free_at[i] - 1);
            mode[i] = int'($urandom_range(0, 3));
            pulse_start(i);
            if ($urandom_range(0, 1) == 1) begin
                at_cyc(cyc + int'($urandom_range(1, 6)));
                pulse_start(i);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x0;
        int pending;
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
        for (int i = 0; i < NI; i++) begin
            mode[i]    = 0;
            free_at[i] = 0;
        end

        // Power-on reset.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed runs: good gate with ignored starts, then stuck-at-1;
        // stuck-at-0 over three runs; OR gate saturating a 2-bit counter.
        fork
            begin
                mode[0] = 0;
                x0 = cyc + 1;
                pulse_start(0);
                at_cyc(x0 + 4);
                pulse_start(0);
                at_cyc(x0 + 12);
                pulse_start(0);
                mode[0] = 1;
                pulse_start(0);
                at_cyc(free_at[0]);
            end
            begin
                mode[1] = 2;
                pulse_start(1);
                at_cyc(free_at[1]);
            end
            begin
                mode[2] = 3;
                pulse_start(2);
                at_cyc(free_at[2]);
            end
        join

        // Two-cycle reset while idle with results still held.
        @(negedge clk);
        rst = 1'b1;
        flush_all();
        repeat (2) @(negedge clk);
        check_zero();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a run at vector 2.
        mode[0] = 0;
        pulse_start(0);
        for (int n = 0; n < 60 && if0.vec_idx != 2'd2; n++) @(negedge clk);
        check("reach_vec2", 0, if0.vec_idx == 2'd2, int'(if0.vec_idx), 2);
        rst = 1'b1;
        flush_all();
        @(negedge clk);
        check_zero();
        rst = 1'b0;
        pulse_start(0);
        at_cyc(free_at[0]);

        // Randomised gate faults, gaps and stray start pulses.
        fork
            rand_runs(0, 8);
            rand_runs(1, 6);
            rand_runs(2, 8);
        join

        pending = 1;
        for (int n = 0; n < 400 && pending != 0; n++) begin
            @(negedge clk);
            pending = rq[0].size() + rq[1].size() + rq[2].size();
        end
        check("drain", 0, pending == 0, pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
